// File: rtl/mine_placer_if.sv
// Level-strobe and cell-query bundle between the level selector, the board
// logic and the mine placer.
interface mine_placer_if;
    logic       level_enable;
    logic [5:0] mines_in;
    logic [4:0] button_num;
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic       rd_mine;
    logic [3:0] rd_count;
    logic       busy;
    logic       mines_ready;
    logic [4:0] grid_n;

    modport master (
        output level_enable, mines_in, button_num, rd_x, rd_y,
        input  rd_mine, rd_count, busy, mines_ready, grid_n
    );

    modport slave (
        input  level_enable, mines_in, button_num, rd_x, rd_y,
        output rd_mine, rd_count, busy, mines_ready, grid_n
    );
endinterface

// File: rtl/mine_placer.sv
// Clears a MAX_GRID x MAX_GRID mine bitmap, scatters the requested mines at
// LFSR-chosen distinct cells, and answers registered mine/neighbour queries.
module mine_placer #(
    parameter int          MAX_GRID  = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic          clk,
    input logic          rst_n,
    mine_placer_if.slave bus
);

    // Cell coordinates are 4 bits wide, so MAX_GRID may not exceed 16.
    localparam logic [3:0] LAST_ROW = 4'(MAX_GRID - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;

    state_t                               state;
    state_t                               next_state;
    logic [15:0]                          lfsr;
    logic [MAX_GRID-1:0][MAX_GRID-1:0]    bitmap;
    logic [5:0]                           remaining;
    logic [3:0]                           row;
    logic [4:0]                           grid_n_q;

    logic       strobe_ok;
    logic [9:0] cells_m1;
    logic [5:0] clamped;
    logic [3:0] cand_x;
    logic [3:0] cand_y;
    logic       cand_ok;
    logic       load;
    logic       clear_en;
    logic       place_en;
    logic       mine_now;
    logic [3:0] count_now;
    logic [4:0] px;
    logic [4:0] py;
    logic [3:0] qx;
    logic [3:0] qy;

    assign strobe_ok = bus.level_enable && (bus.button_num != 5'd0)
                       && (bus.button_num <= 5'(MAX_GRID));
    assign cells_m1  = 10'(bus.button_num) * 10'(bus.button_num) - 10'd1;
    assign clamped   = ({4'b0, bus.mines_in} < cells_m1) ? bus.mines_in : cells_m1[5:0];

    assign cand_x  = lfsr[3:0];
    assign cand_y  = lfsr[7:4];
    assign cand_ok = ({1'b0, cand_x} < grid_n_q) && ({1'b0, cand_y} < grid_n_q)
                     && !bitmap[cand_y][cand_x];

    always_comb begin
        next_state = state;
        load       = 1'b0;
        clear_en   = 1'b0;
        place_en   = 1'b0;
        case (state)
            IDLE: begin
                if (strobe_ok) begin
                    load       = 1'b1;
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                clear_en = 1'b1;
                if (row == LAST_ROW) begin
                    next_state = (remaining == 6'd0) ? DONE : PLACE;
                end
            end
            PLACE: begin
                if (cand_ok) begin
                    place_en = 1'b1;
                    if (remaining == 6'd1) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status flags are registered from next_state so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.mines_ready <= 1'b0;
        end else begin
            state           <= next_state;
            bus.busy        <= (next_state == CLEAR) || (next_state == PLACE);
            bus.mines_ready <= (next_state == DONE);
        end
    end

    // Galois LFSR free-runs in every state; strobe timing supplies the entropy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= LFSR_SEED;
            bitmap    <= '0;
            remaining <= 6'd0;
            row       <= 4'd0;
            grid_n_q  <= 5'd0;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (load) begin
                grid_n_q  <= bus.button_num;
                remaining <= clamped;
                row       <= 4'd0;
            end
            if (clear_en) begin
                bitmap[row] <= '0;
                row         <= row + 4'd1;
            end
            if (place_en) begin
                bitmap[cand_y][cand_x] <= 1'b1;
                remaining              <= remaining - 6'd1;
            end
        end
    end

    assign bus.grid_n = grid_n_q;

    assign mine_now = ({1'b0, bus.rd_x} < grid_n_q) && ({1'b0, bus.rd_y} < grid_n_q)
                      && bitmap[bus.rd_y][bus.rd_x];

    // px/py hold neighbour coordinates offset by +1 so the -1 column stays unsigned.
    always_comb begin
        count_now = 4'd0;
        px        = 5'd0;
        py        = 5'd0;
        qx        = 4'd0;
        qy        = 4'd0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                px = {1'b0, bus.rd_x} + 5'(dx);
                py = {1'b0, bus.rd_y} + 5'(dy);
                qx = px[3:0] - 4'd1;
                qy = py[3:0] - 4'd1;
                if (!(dx == 1 && dy == 1) && (px != 5'd0) && (py != 5'd0)
                    && (px <= grid_n_q) && (py <= grid_n_q)) begin
                    count_now = count_now + {3'b000, bitmap[qy][qx]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_mine  <= 1'b0;
            bus.rd_count <= 4'd0;
        end else begin
            bus.rd_mine  <= mine_now;
            bus.rd_count <= count_now;
        end
    end

endmodule

// File: tb/tb_mine_placer.sv
// Scoreboard bench for mine_placer: directed strobes, a spec-level layout
// predictor, and a monitor that checks every registered cell query.
module tb_mine_placer;

    logic clk;
    logic rst_n;

    mine_placer_if bus ();

    mine_placer #(
        .MAX_GRID (16),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int         x;
        int         y;
        logic       mine;
        logic [3:0] count;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    int          dut_ones;
    logic        q_issue;
    logic [15:0] m_lfsr;
    bit   [15:0] mdl_map[16];
    int          mdl_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Free-running reference LFSR, used only to snapshot the value at each strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (q_issue === 1'b1) begin
                exp_t e;
                #1;
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("rd_mine(%0d,%0d)", e.x, e.y), int'(bus.rd_mine), int'(e.mine));
                    checkOutput($sformatf("rd_count(%0d,%0d)", e.x, e.y), int'(bus.rd_count), int'(e.count));
                    if (bus.rd_mine === 1'b1) dut_ones++;
                end
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mdl_map[i] = '0;
        mdl_n = 0;
    endtask

    // Replays placement from the LFSR value seen in the strobe cycle.
    task automatic predict_layout(input logic [15:0] l_strobe, input int n, input int mines,
                                  output int lat);
        logic [15:0] l;
        int rem, x, y, p;
        clear_model();
        mdl_n = n;
        rem = (mines < n * n - 1) ? mines : n * n - 1;
        l = l_strobe;
        repeat (17) l = lfsr_step(l);
        p = 0;
        while (rem > 0 && p < 40000) begin
            x = int'(l[3:0]);
            y = int'(l[7:4]);
            if (x < n && y < n && !mdl_map[y][x]) begin
                mdl_map[y][x] = 1'b1;
                rem--;
            end
            l = lfsr_step(l);
            p++;
        end
        lat = 17 + p;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input int mines, input int n, output logic [15:0] snap);
        @(negedge clk);
        bus.mines_in     = 6'(mines);
        bus.button_num   = 5'(n);
        bus.level_enable = 1'b1;
        snap = m_lfsr;
        @(posedge clk);
        #1;
        bus.level_enable = 1'b0;
    endtask

    task automatic wait_ready(input int bound, input int sec_at, output int lat);
        lat = 1;
        while (bus.mines_ready !== 1'b1 && lat < bound) begin
            @(negedge clk);
            if (lat == sec_at) begin
                bus.mines_in     = 6'd60;
                bus.button_num   = 5'd5;
                bus.level_enable = 1'b1;
            end else begin
                bus.level_enable = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.level_enable = 1'b0;
        if (bus.mines_ready !== 1'b1) checkOutput("ready_timeout", 0, 1);
    endtask

    task automatic query_cell(input int x, input int y);
        exp_t e;
        int   c;
        e.x = x;
        e.y = y;
        e.mine = (x < mdl_n && y < mdl_n) ? mdl_map[y][x] : 1'b0;
        c = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (!(dx == 0 && dy == 0) && x + dx >= 0 && y + dy >= 0
                    && x + dx < mdl_n && y + dy < mdl_n) begin
                    c += int'(mdl_map[y + dy][x + dx]);
                end
            end
        end
        e.count = 4'(c);
        @(negedge clk);
        bus.rd_x = 4'(x);
        bus.rd_y = 4'(y);
        q_issue  = 1'b1;
        sb.push_back(e);
    endtask

    task automatic sweep_board(input string name, input int expected_ones);
        dut_ones = 0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                query_cell(x, y);
            end
        end
        @(negedge clk);
        q_issue = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput({name, "_drain"}, sb.size(), 0);
        checkOutput({name, "_ones"}, dut_ones, expected_ones);
    endtask

    initial begin
        logic [15:0] snap;
        int exp_lat, lat;
        rst_n            = 1'b0;
        bus.level_enable = 1'b0;
        bus.mines_in     = '0;
        bus.button_num   = '0;
        bus.rd_x         = '0;
        bus.rd_y         = '0;
        q_issue          = 1'b0;
        total            = 0;
        bad              = 0;
        dut_ones         = 0;
        clear_model();

        #12;
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_ready", int'(bus.mines_ready), 0);
        checkOutput("rst_grid_n", int'(bus.grid_n), 0);
        checkOutput("rst_rd_mine", int'(bus.rd_mine), 0);
        checkOutput("rst_rd_count", int'(bus.rd_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal grid sizes in IDLE must be ignored.
        repeat (30) @(posedge clk);
        applyStimulus(5, 0, snap);
        checkOutput("n0_busy", int'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("n0_grid_n", int'(bus.grid_n), 0);
        applyStimulus(5, 20, snap);
        checkOutput("n20_busy", int'(bus.busy), 0);
        checkOutput("n20_grid_n", int'(bus.grid_n), 0);
        repeat (60) @(posedge clk);

        // Level 1 with a second strobe injected during PLACE.
        applyStimulus(19, 8, snap);
        checkOutput("l1_busy_rise", int'(bus.busy), 1);
        predict_layout(snap, 8, 19, exp_lat);
        wait_ready(5000, 20, lat);
        checkOutput("l1_latency", lat, exp_lat);
        checkOutput("l1_grid_n", int'(bus.grid_n), 8);
        checkOutput("l1_busy_done", int'(bus.busy), 0);
        sweep_board("l1", 19);

        // Level 3, reset mid-PLACE, then an identical replay.
        do_reset();
        repeat (100) @(posedge clk);
        applyStimulus(63, 16, snap);
        repeat (28) @(posedge clk);
        #1;
        checkOutput("l3_busy_mid", int'(bus.busy), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", int'(bus.busy), 0);
        checkOutput("mid_rst_ready", int'(bus.mines_ready), 0);
        checkOutput("mid_rst_grid_n", int'(bus.grid_n), 0);
        checkOutput("mid_rst_rd_mine", int'(bus.rd_mine), 0);
        checkOutput("mid_rst_rd_count", int'(bus.rd_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        sweep_board("post_rst", 0);

        do_reset();
        repeat (100) @(posedge clk);
        applyStimulus(63, 16, snap);
        predict_layout(snap, 16, 63, exp_lat);
        wait_ready(5000, -1, lat);
        checkOutput("l3_latency", lat, exp_lat);
        checkOutput("l3_grid_n", int'(bus.grid_n), 16);
        sweep_board("l3", 63);

        // Clamp: 10 mines requested on a 3x3 board leaves one free cell.
        do_reset();
        repeat (50) @(posedge clk);
        applyStimulus(10, 3, snap);
        predict_layout(snap, 3, 10, exp_lat);
        wait_ready(40000, -1, lat);
        checkOutput("clamp_latency", lat, exp_lat);
        checkOutput("clamp_ready", int'(bus.mines_ready), 1);
        checkOutput("clamp_grid_n", int'(bus.grid_n), 3);
        sweep_board("clamp", 8);

        // Zero mines: DONE straight after the 16 clear cycles.
        do_reset();
        repeat (20) @(posedge clk);
        applyStimulus(0, 10, snap);
        checkOutput("zero_busy_rise", int'(bus.busy), 1);
        predict_layout(snap, 10, 0, exp_lat);
        wait_ready(200, -1, lat);
        checkOutput("zero_latency", lat, 17);
        checkOutput("zero_grid_n", int'(bus.grid_n), 10);
        sweep_board("zero", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
